// File: rtl/vend_pkg.sv
// Shared types for the vending machine and the payment terminal:
// state encoding, balance/cost widths and the saturating credit add.
package vend_pkg;

    localparam int BAL_W    = 6;
    localparam int COST_W   = 3;
    localparam int AMT_W    = 5;
    localparam int ID_W     = 2;
    localparam int NUM_ACCT = 4;

    typedef logic [BAL_W-1:0]  bal_t;
    typedef logic [COST_W-1:0] cost_t;
    typedef logic [AMT_W-1:0]  amt_t;
    typedef logic [ID_W-1:0]   acct_id_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_COST,
        AUTH,
        APPROVE,
        DECLINE,
        DONE
    } state_t;

    // Credit add that clamps at the largest representable balance.
    function automatic bal_t sat_add(input bal_t bal, input amt_t amt);
        logic [BAL_W:0] sum;
        sum = {1'b0, bal} + (BAL_W + 1)'(amt);
        return sum[BAL_W] ? '1 : sum[BAL_W-1:0];
    endfunction

endpackage

// File: rtl/payment_terminal_if.sv
// Card/vending-machine side of the payment terminal; the terminal is the slave.
interface payment_terminal_if import vend_pkg::*; ();

    logic     card_in;
    acct_id_t card_id;
    cost_t    cost;
    logic     vend;
    logic     topup;
    acct_id_t topup_id;
    amt_t     topup_amt;
    logic     valid_tran;
    logic     declined;
    bal_t     balance;
    logic     busy;

    modport master (
        output card_in, card_id, cost, vend, topup, topup_id, topup_amt,
        input  valid_tran, declined, balance, busy
    );

    modport slave (
        input  card_in, card_id, cost, vend, topup, topup_id, topup_amt,
        output valid_tran, declined, balance, busy
    );

endinterface

// File: rtl/account_bank.sv
// Four account balances with a saturating top-up port, a debit port and
// one combinational read port.
module account_bank import vend_pkg::*; #(
    parameter int INIT_BAL = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    input  acct_id_t rd_id,
    output bal_t     rd_bal,
    input  logic     topup_en,
    input  acct_id_t topup_id,
    input  amt_t     topup_amt,
    input  logic     debit_en,
    input  acct_id_t debit_id,
    input  cost_t    debit_amt
);

    bal_t bal_q [NUM_ACCT];
    bal_t bal_d [NUM_ACCT];

    // Debits are only issued after a bal >= cost check, so they cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_ACCT; i++) begin
            bal_d[i] = bal_q[i];
            if (topup_en && topup_id == ID_W'(i)) begin
                bal_d[i] = sat_add(bal_q[i], topup_amt);
            end else if (debit_en && debit_id == ID_W'(i)) begin
                bal_d[i] = bal_q[i] - BAL_W'(debit_amt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                bal_q[i] <= BAL_W'(INIT_BAL);
            end
        end else begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                bal_q[i] <= bal_d[i];
            end
        end
    end

    assign rd_bal = bal_q[rd_id];

endmodule

// File: rtl/payment_terminal.sv
// Card payment terminal: latches the card account, authorises a vending price
// against the account balance and debits it once the machine dispenses.
module payment_terminal import vend_pkg::*; #(
    parameter int AUTH_LAT = 2,
    parameter int TIMEOUT  = 8,
    parameter int INIT_BAL = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    payment_terminal_if.slave   bus
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    acct_id_t       acct_q, acct_d;
    cost_t          cost_q, cost_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [1:0]     auth_q, auth_d;
    logic           valid_q, valid_d;
    logic           declined_q, declined_d;
    logic           busy_q, busy_d;
    logic           debit_en;
    bal_t           cur_bal;

    account_bank #(.INIT_BAL(INIT_BAL)) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_id     (acct_q),
        .rd_bal    (cur_bal),
        .topup_en  (bus.topup && state_q == IDLE),
        .topup_id  (bus.topup_id),
        .topup_amt (bus.topup_amt),
        .debit_en  (debit_en),
        .debit_id  (acct_q),
        .debit_amt (cost_q)
    );

    always_comb begin
        state_d  = state_q;
        acct_d   = acct_q;
        cost_d   = cost_q;
        wait_d   = wait_q;
        auth_d   = auth_q;
        debit_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.card_in) begin
                    state_d = WAIT_COST;
                    acct_d  = bus.card_id;
                end
            end
            WAIT_COST: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (bus.cost != '0) begin
                    state_d = AUTH;
                    cost_d  = bus.cost;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            AUTH: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (auth_q == 2'(AUTH_LAT - 1)) begin
                    state_d = (cur_bal >= BAL_W'(cost_q)) ? APPROVE : DECLINE;
                end else begin
                    auth_d = auth_q + 1'b1;
                end
            end
            // Card removal is ignored here: the machine may already be dispensing.
            APPROVE: begin
                if (bus.vend) begin
                    state_d  = DONE;
                    debit_en = 1'b1;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECLINE, DONE: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
            auth_d = '0;
        end

        valid_d    = (state_d == APPROVE);
        declined_d = (state_d == DECLINE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acct_q     <= '0;
            cost_q     <= '0;
            wait_q     <= '0;
            auth_q     <= '0;
            valid_q    <= 1'b0;
            declined_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acct_q     <= acct_d;
            cost_q     <= cost_d;
            wait_q     <= wait_d;
            auth_q     <= auth_d;
            valid_q    <= valid_d;
            declined_q <= declined_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.valid_tran = valid_q;
    assign bus.declined   = declined_q;
    assign bus.busy       = busy_q;
    assign bus.balance    = cur_bal;

endmodule

// File: tb/tb_payment_terminal.sv
// Scenario bench for payment_terminal with a per-account balance model and
// randomized purchase/top-up traffic.
module tb_payment_terminal;
    import vend_pkg::*;

    localparam int AUTH_LAT = 2;
    localparam int TIMEOUT  = 8;
    localparam int INIT_BAL = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    payment_terminal_if bus();

    payment_terminal #(
        .AUTH_LAT (AUTH_LAT),
        .TIMEOUT  (TIMEOUT),
        .INIT_BAL (INIT_BAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int model_bal [NUM_ACCT];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_ACCT; i++) model_bal[i] = INIT_BAL;
    endtask

    task automatic do_topup(input int id, input int amt, input bit expect_accept);
        bus.topup     = 1'b1;
        bus.topup_id  = id[ID_W-1:0];
        bus.topup_amt = amt[AMT_W-1:0];
        step(1);
        bus.topup = 1'b0;
        if (expect_accept) model_bal[id] = (model_bal[id] + amt > 63) ? 63 : model_bal[id] + amt;
    endtask

    task automatic peek_balance(input int id, input string tag);
        bus.card_in = 1'b1;
        bus.card_id = id[ID_W-1:0];
        step(1);
        checks++;
        if (bus.balance !== 6'(model_bal[id])) begin
            failures++;
            $display("[TB] FAIL %s balance acct%0d: got %0d expected %0d", tag, id, bus.balance, model_bal[id]);
        end
        bus.card_in = 1'b0;
        step(1);
    endtask

    task automatic purchase(input int id, input int c, input bit do_vend, input string tag);
        bit approve;
        bus.card_in = 1'b1;
        bus.card_id = id[ID_W-1:0];
        step(1);
        checks++;
        if (bus.balance !== 6'(model_bal[id]) || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s insert: got bal=%0d busy=%b expected bal=%0d busy=1", tag, bus.balance, bus.busy, model_bal[id]);
        end
        bus.cost = c[COST_W-1:0];
        step(AUTH_LAT);
        checks++;
        if ({bus.valid_tran, bus.declined} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL %s early_strobe: got %b expected 00", tag, {bus.valid_tran, bus.declined});
        end
        step(1);
        bus.cost = '0;
        approve = (model_bal[id] >= c);
        checks++;
        if ({bus.valid_tran, bus.declined} !== {approve, !approve}) begin
            failures++;
            $display("[TB] FAIL %s strobe: got valid/declined=%b expected %b", tag, {bus.valid_tran, bus.declined}, {approve, !approve});
        end
        if (approve && do_vend) begin
            bus.vend = 1'b1;
            step(1);
            bus.vend = 1'b0;
            model_bal[id] -= c;
            checks++;
            if ({bus.valid_tran, bus.declined, bus.busy} !== 3'b001 || bus.balance !== 6'(model_bal[id])) begin
                failures++;
                $display("[TB] FAIL %s done: got vdb=%b bal=%0d expected vdb=001 bal=%0d", tag, {bus.valid_tran, bus.declined, bus.busy}, bus.balance, model_bal[id]);
            end
            bus.card_in = 1'b0;
            step(1);
        end else if (approve) begin
            bus.card_in = 1'b0;
            step(TIMEOUT - 1);
            checks++;
            if (bus.valid_tran !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s approve_hold: got valid=%b expected 1", tag, bus.valid_tran);
            end
            step(1);
        end else begin
            bus.card_in = 1'b0;
            step(1);
        end
        checks++;
        if ({bus.valid_tran, bus.declined, bus.busy} !== 3'b000 || bus.balance !== 6'(model_bal[id])) begin
            failures++;
            $display("[TB] FAIL %s idle: got vdb=%b bal=%0d expected vdb=000 bal=%0d", tag, {bus.valid_tran, bus.declined, bus.busy}, bus.balance, model_bal[id]);
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({bus.valid_tran, bus.declined, bus.busy} !== 3'b000 || bus.balance !== 6'(INIT_BAL)) begin
            failures++;
            $display("[TB] FAIL reset_state: got vdb=%b bal=%0d expected vdb=000 bal=%0d", {bus.valid_tran, bus.declined, bus.busy}, bus.balance, INIT_BAL);
        end
        rst_n = 1'b1;
        model_reset();
        step(1);
    endtask

    task automatic test_basic_purchase();
        purchase(1, 4, 1'b1, "basic");
    endtask

    task automatic test_topup_saturate();
        do_topup(2, 5, 1'b1);
        peek_balance(2, "topup5");
        do_topup(2, 31, 1'b1);
        peek_balance(2, "topup31");
        do_topup(2, 31, 1'b1);
        peek_balance(2, "topup_sat");
        do_topup(2, $urandom_range(1, 31), 1'b1);
        peek_balance(2, "topup_sat_rand");
        purchase(2, 6, 1'b1, "sat_purchase");
    endtask

    task automatic test_decline();
        purchase(0, 7, 1'b1, "drain1");
        purchase(0, 7, 1'b1, "drain2");
        purchase(0, 3, 1'b1, "drain3");
        purchase(0, 5, 1'b1, "decline");
        peek_balance(0, "decline_bal");
    endtask

    task automatic test_approve_timeout();
        purchase(3, $urandom_range(1, 7), 1'b0, "timeout");
    endtask

    task automatic test_auth_abort();
        int id;
        id = $urandom_range(0, 3);
        bus.card_in = 1'b1;
        bus.card_id = id[ID_W-1:0];
        step(1);
        bus.cost = 3'($urandom_range(1, 7));
        step(2);
        bus.card_in = 1'b0;
        bus.cost    = '0;
        step(1);
        checks++;
        if ({bus.valid_tran, bus.declined, bus.busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL auth_abort: got vdb=%b expected 000", {bus.valid_tran, bus.declined, bus.busy});
        end
        step(3);
        checks++;
        if ({bus.valid_tran, bus.declined} !== 2'b00 || bus.balance !== 6'(model_bal[id])) begin
            failures++;
            $display("[TB] FAIL auth_abort_after: got vd=%b bal=%0d expected vd=00 bal=%0d", {bus.valid_tran, bus.declined}, bus.balance, model_bal[id]);
        end
    endtask

    task automatic test_reset_in_approve();
        int id;
        int c;
        id = $urandom_range(1, 3);
        c  = $urandom_range(1, (model_bal[id] < 7) ? model_bal[id] : 7);
        bus.card_in = 1'b1;
        bus.card_id = id[ID_W-1:0];
        step(1);
        bus.cost = c[COST_W-1:0];
        step(AUTH_LAT + 1);
        bus.cost = '0;
        checks++;
        if (bus.valid_tran !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_approve_pre: got valid=%b expected 1", bus.valid_tran);
        end
        bus.vend = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.valid_tran, bus.declined, bus.busy} !== 3'b000 || bus.balance !== 6'(INIT_BAL)) begin
            failures++;
            $display("[TB] FAIL rst_approve_clear: got vdb=%b bal=%0d expected vdb=000 bal=%0d", {bus.valid_tran, bus.declined, bus.busy}, bus.balance, INIT_BAL);
        end
        bus.vend    = 1'b0;
        bus.card_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        peek_balance(id, "rst_approve_bal");
    endtask

    task automatic test_topup_busy();
        int tid;
        tid = $urandom_range(0, 3);
        bus.card_in = 1'b1;
        bus.card_id = 2'($urandom_range(0, 3));
        step(1);
        do_topup(tid, $urandom_range(1, 31), 1'b0);
        bus.cost = 3'd1;
        step(1);
        bus.cost = '0;
        do_topup(tid, $urandom_range(1, 31), 1'b0);
        bus.card_in = 1'b0;
        step(2);
        peek_balance(tid, "topup_busy");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_topup($urandom_range(0, 3), $urandom_range(0, 31), 1'b1);
            end else begin
                purchase($urandom_range(0, 3), $urandom_range(1, 7), 1'($urandom_range(0, 1)), "random");
            end
        end
    endtask

    initial begin
        bus.card_in   = 1'b0;
        bus.card_id   = '0;
        bus.cost      = '0;
        bus.vend      = 1'b0;
        bus.topup     = 1'b0;
        bus.topup_id  = '0;
        bus.topup_amt = '0;
        model_reset();
        test_reset();
        test_basic_purchase();
        test_topup_saturate();
        test_decline();
        test_approve_timeout();
        test_auth_abort();
        test_reset_in_approve();
        test_topup_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/payment_terminal.md
PAYMENT_TERMINAL -- requirements
Module: payment_terminal

Interface
REQ-001 Parameters SHALL be: AUTH_LAT, default 2, authorization processing cycles; TIMEOUT, default 8, max wait cycles in WAIT_COST and APPROVE; INIT_BAL, default 20, per-account balance after reset.
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 CARD_IN  input  1  card inserted; level.
REQ-006 CARD_ID  input  2  account select, sampled on card insertion.
REQ-007 COST  input  3  price from vending machine; nonzero means price requested.
REQ-008 VEND  input  1  vending machine dispensing acknowledge.
REQ-009 TOPUP  input  1  one-cycle credit-load strobe.
REQ-010 TOPUP_ID  input  2  account to credit.
REQ-011 TOPUP_AMT  input  5  credit amount.
REQ-012 VALID_TRAN  output  1  payment approved; level.
REQ-013 DECLINED  output  1  payment refused; level.
REQ-014 BALANCE  output  6  balance of the latched account.
REQ-015 BUSY  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_COST, AUTH, APPROVE, DECLINE, DONE, all registered on CLK.
REQ-017 IDLE: CARD_IN=1 -> WAIT_COST, latching CARD_ID into acct and clearing the wait counter.
REQ-018 WAIT_COST: COST!=0 -> AUTH, latching COST into cost_q; CARD_IN=0 -> IDLE; wait counter reaching TIMEOUT -> IDLE; CARD_IN=0 has priority.
REQ-019 AUTH: after exactly AUTH_LAT cycles in AUTH, go to APPROVE if bal[acct] >= cost_q, else DECLINE; CARD_IN=0 in any AUTH cycle -> IDLE.
REQ-020 APPROVE: VALID_TRAN=1; VEND=1 -> debit bal[acct] by cost_q and go to DONE; wait counter reaching TIMEOUT with no VEND -> IDLE with no debit; VEND and timeout in the same cycle SHALL count as VEND.
REQ-021 Removing CARD_IN in APPROVE SHALL NOT abort it, because the machine may already be vending.
REQ-022 DECLINE: DECLINED=1; CARD_IN=0 -> IDLE.
REQ-023 DONE: CARD_IN=0 -> IDLE; no outputs asserted other than BUSY.
REQ-024 VALID_TRAN and DECLINED SHALL be registered, mutually exclusive, and asserted from the first cycle of their state.
REQ-025 Latency from COST becoming nonzero to VALID_TRAN or DECLINED rising SHALL be AUTH_LAT+1 cycles, and SHALL be less than 4.
REQ-026 Balances SHALL be four 6-bit registers, and a debit SHALL never underflow, since approval requires bal >= cost_q.
REQ-027 TOPUP SHALL be accepted only in IDLE, adding TOPUP_AMT to bal[TOPUP_ID] and saturating at 63.
REQ-028 TOPUP outside IDLE SHALL be ignored.
REQ-029 The wait counter SHALL clear on every state entry and SHALL increment each cycle in WAIT_COST and APPROVE.
REQ-030 BALANCE SHALL show bal[acct] and update the cycle after a debit.

Reset
REQ-031 RESET_N=0 SHALL, asynchronously: force state to IDLE; clear VALID_TRAN, DECLINED and BUSY; clear acct, cost_q and the counters; set all balances to INIT_BAL.
REQ-032 BALANCE SHALL read INIT_BAL after reset.
REQ-033 Reset during APPROVE SHALL discard any pending debit.
REQ-034 Release of RESET_N SHALL take effect at the next rising edge of CLK.

Structure
REQ-035 The state encoding, the 6-bit balance width and the 3-bit cost width SHALL live in a shared package, vend_pkg, used by both the vending machine and this block.
REQ-036 The balance array, with its saturating add and debit port, SHALL be one sub-module, account_bank.

Verification
REQ-037 Reset; CARD_IN=1, CARD_ID=1; COST=4 -> VALID_TRAN=1 exactly 3 cycles later; VEND=1 -> BALANCE=16, state DONE; CARD_IN=0 -> IDLE.
REQ-038 TOPUP account 2 with 5, then with 31 -> balance 56, then 63 (saturated); card 2 with COST=6 and VEND -> BALANCE=57.
REQ-039 Account 0 at balance 3; COST=5 -> DECLINED=1 and VALID_TRAN=0, balance unchanged at 3.
REQ-040 Approve on account 3, hold VEND=0 for 8 cycles -> return to IDLE, balance still 20, VALID_TRAN drops.
REQ-041 Drop CARD_IN in the second AUTH cycle -> IDLE, no strobe.
REQ-042 Assert RESET_N=0 during APPROVE -> outputs clear immediately and the balance returns to 20.
REQ-043 Assert TOPUP while BUSY -> no balance change.
